// File: rtl/alu_slice_sequencer.sv
// rtl/alu_slice_sequencer.sv - runs 16-bit ALU ops nibble-serially through one 4-bit ALU slice
//
// Purpose: accepts two W-bit operands and an opcode. It then walks the operands
// through an external combinational 4-bit ALU slice, LSB nibble first, one nibble
// per cycle. The slice carry goes through a register between nibbles. The wide
// result and flags are held until the consumer accepts them.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_op           operands and opcode, latched on accept
//   out_valid/out_ready         result handshake (result held until accepted)
//   out_result                  W-bit result
//   out_cout, out_overflow,
//   out_zero, out_err           result flags
//   alu_a, alu_b, alu_cin,
//   alu_less, alu_op            drive the slice (registered state only)
//   alu_result, alu_cout,
//   alu_overflow                slice outputs, sampled on every RUN edge

module alu_slice_sequencer #(
  parameter int NSLICES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NSLICES-1:0]   in_a,
  input  logic [4*NSLICES-1:0]   in_b,
  input  logic [2:0]             in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NSLICES-1:0]   out_result,
  output logic                   out_cout,
  output logic                   out_overflow,
  output logic                   out_zero,
  output logic                   out_err,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic                   alu_less,
  output logic [2:0]             alu_op,
  input  logic [3:0]             alu_result,
  input  logic                   alu_cout,
  input  logic                   alu_overflow
);

  localparam int W  = 4 * NSLICES;
  localparam int IW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICES - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, res_q;
  logic [2:0]      op_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            ovf_q;

  logic            accept;
  logic            last_slice;
  logic            is_legal;
  logic            is_arith;
  logic            is_subtract;
  logic            is_done;
  logic [W-1:0]    final_res;

  assign accept     = (state_q == S_IDLE) && in_valid;
  assign last_slice = (idx_q == LAST_IDX);
  assign is_done    = (state_q == S_DONE);

  // Opcode decode on the latched opcode
  assign is_arith    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
  assign is_subtract = (op_q == OP_SUB) || (op_q == OP_SLT);
  assign is_legal    = is_arith || (op_q == OP_AND) || (op_q == OP_OR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)   state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, nibble accumulator and carry chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b;
      op_q    <= in_op;
      idx_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == S_RUN) begin
      for (int i = 0; i < NSLICES; i++) begin
        if (idx_q == IW'(i)) begin
          res_q[4*i +: 4] <= alu_result;
        end
      end
      carry_q <= alu_cout;
      if (last_slice) begin
        // Only the top slice's overflow is meaningful for the wide operation
        ovf_q <= alu_overflow;
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Slice drive. The slice is driven only in RUN, so the slice inputs stay at
  // their reset values while the sequencer waits.
  always_comb begin
    alu_a   = 4'h0;
    alu_b   = 4'h0;
    alu_cin = 1'b0;
    alu_op  = 3'b000;
    if (state_q == S_RUN) begin
      for (int i = 0; i < NSLICES; i++) begin
        if (idx_q == IW'(i)) begin
          alu_a = a_q[4*i +: 4];
          alu_b = b_q[4*i +: 4];
        end
      end
      // SLT runs as a full subtract; the less-than bit is derived at the end
      alu_op = (op_q == OP_SLT) ? OP_SUB : op_q;
      if (idx_q == '0) begin
        alu_cin = is_subtract;
      end else begin
        alu_cin = is_arith & carry_q;
      end
    end
  end

  assign alu_less = 1'b0;

  // Final result: the sign of the true difference is msb XOR overflow
  always_comb begin
    final_res = res_q;
    if (!is_legal) begin
      final_res = '0;
    end else if (op_q == OP_SLT) begin
      final_res = {{(W-1){1'b0}}, res_q[W-1] ^ ovf_q};
    end
  end

  // Outputs are gated by DONE so no partial result is ever visible
  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = is_done;
  assign out_result   = is_done ? final_res : '0;
  assign out_cout     = is_done & is_arith & carry_q;
  assign out_overflow = is_done & ((op_q == OP_ADD) || (op_q == OP_SUB)) & ovf_q;
  assign out_zero     = is_done & (final_res == '0);
  assign out_err      = is_done & ~is_legal;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb/tb_alu_slice_sequencer.sv - self-checking bench for alu_slice_sequencer with a 4-bit slice model

module tb_alu_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_cout, out_overflow, out_zero, out_err;
  logic [3:0]  alu_a, alu_b;
  logic        alu_cin, alu_less;
  logic [2:0]  alu_op;
  logic [3:0]  alu_result;
  logic        alu_cout, alu_overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_slice_sequencer #(.NSLICES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_cout     (out_cout),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .out_err      (out_err),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_less     (alu_less),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow)
  );

  // Downstream FourBitALU slice: op[2] inverts b, op[1:0] selects AND/OR/ADD/LESS
  logic [3:0] slice_b;
  logic [4:0] slice_sum;
  always_comb begin
    slice_b      = alu_op[2] ? ~alu_b : alu_b;
    slice_sum    = {1'b0, alu_a} + {1'b0, slice_b} + {4'b0, alu_cin};
    alu_cout     = slice_sum[4];
    alu_overflow = (alu_a[3] == slice_b[3]) && (slice_sum[3] != alu_a[3]);
    case (alu_op[1:0])
      2'b00:   alu_result = alu_a & slice_b;
      2'b01:   alu_result = alu_a | slice_b;
      2'b10:   alu_result = slice_sum[3:0];
      default: alu_result = {3'b000, alu_less};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model on whole 16-bit words
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                                    output logic [15:0] r, output logic c, output logic o,
                                    output logic z, output logic e);
    logic [16:0] s;
    r = 16'h0; c = 1'b0; o = 1'b0; e = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0]; c = s[16];
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'b110: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        r = a - b; c = s[16];
        o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'b111: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        c = s[16];
        r = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      end
      default: e = 1'b1;
    endcase
    z = (r == 16'h0);
  endfunction

  // Expected carry into each nibble: carry out of the low 4k bits of the word sum
  function automatic logic [3:0] exp_cin(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    logic [15:0] bb;
    logic        c0;
    logic [16:0] mask, s;
    logic [3:0]  v;
    v = 4'b0000;
    if (op == 3'b010 || op == 3'b110 || op == 3'b111) begin
      c0 = (op != 3'b010);
      bb = c0 ? ~b : b;
      v[0] = c0;
      for (int k = 1; k < 4; k++) begin
        mask = (17'd1 << (4 * k)) - 17'd1;
        s = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + {16'b0, c0};
        v[k] = s[4 * k];
      end
    end
    return v;
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    // Scramble inputs while running; the DUT must ignore them
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_op = 3'($urandom);
  endtask

  task automatic wait_done(output int lat, output logic [3:0] cin_seen);
    logic got, less_seen;
    got = 1'b0; less_seen = 1'b0; lat = 0; cin_seen = 4'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      check("no_partial_result", out_result, 0);
      less_seen = less_seen | alu_less;
      if (k < 4) cin_seen = {alu_cin, cin_seen[3:1]};
      @(posedge clk);
      lat++;
    end
    check("out_valid_timeout", got, 1);
    check("alu_less_zero", less_seen, 0);
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_take", in_ready, 1);
    check("out_valid_after_take", out_valid, 0);
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                               input logic [15:0] er, input logic ec, input logic eo, input logic ez, input logic ee);
    int lat;
    logic [3:0] cin_seen;
    start_op(a, b, op);
    wait_done(lat, cin_seen);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_cin_ripple"}, cin_seen, exp_cin(a, b, op));
    check({tag, "_result"}, out_result, er);
    check({tag, "_cout"}, out_cout, ec);
    check({tag, "_overflow"}, out_overflow, eo);
    check({tag, "_zero"}, out_zero, ez);
    check({tag, "_err"}, out_err, ee);
    finish_op();
  endtask

  typedef struct {
    string       name;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic [15:0] res;
    logic        c, o, z, e;
  } vec_t;

  vec_t vt[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] r, ra, rb;
    logic [2:0]  rop;
    logic        c, o, z, e;
    logic [15:0] held;

    vt[0]  = '{"add_1_1",     16'h0001, 16'h0001, 3'b010, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{"add_ffff_1",  16'hFFFF, 16'h0001, 3'b010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{"sub_4_1",     16'h0004, 16'h0001, 3'b110, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{"add_7fff_1",  16'h7FFF, 16'h0001, 3'b010, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{"slt_8000_1",  16'h8000, 16'h0001, 3'b111, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{"slt_7fff_8k", 16'h7FFF, 16'h8000, 3'b111, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{"slt_3_3",     16'h0003, 16'h0003, 3'b111, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{"and",         16'hF0F0, 16'h0FF0, 3'b000, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{"or",          16'hF0F0, 16'h0FF0, 3'b001, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{"ill_101",     16'hF0F0, 16'h0FF0, 3'b101, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[10] = '{"ill_011",     16'h1234, 16'h4321, 3'b011, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[11] = '{"sub_0_1",     16'h0000, 16'h0001, 3'b110, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_flags", {out_cout, out_overflow, out_zero, out_err}, 0);
    check("rst_alu_ab", {alu_a, alu_b}, 0);
    check("rst_alu_ctl", {alu_cin, alu_less, alu_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_and_check(vt[i].name, vt[i].a, vt[i].b, vt[i].op, vt[i].res, vt[i].c, vt[i].o, vt[i].z, vt[i].e);
    end

    // Backpressure: outputs hold, new inputs ignored, in_ready stays low
    begin
      int lat;
      logic [3:0] cs;
      start_op(16'h1234, 16'h1111, 3'b010);
      wait_done(lat, cs);
      held = out_result;
      check("bp_result", held, 16'h2345);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        in_a = 16'hFFFF; in_b = 16'hFFFF; in_op = 3'b110; in_valid = 1'b1;
        check("bp_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        check("bp_out_valid_held", out_valid, 1);
        check("bp_result_held", out_result, 16'h2345);
        check("bp_flags_held", {out_cout, out_overflow, out_zero, out_err}, 0);
      end
      in_valid = 1'b0;
      finish_op();
    end

    // Asynchronous reset in RUN after slice 1 has been stored
    start_op(16'hABCD, 16'h1111, 3'b010);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_result", out_result, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_alu", {alu_a, alu_b, alu_cin, alu_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("post_rst_add", 16'h1234, 16'h1111, 3'b010, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized operations against the word-level model
    for (int n = 0; n < 150; n++) begin
      ra  = 16'($urandom);
      rb  = (n % 10 == 0) ? ra : 16'($urandom);
      rop = 3'($urandom_range(0, 7));
      ref_model(ra, rb, rop, r, c, o, z, e);
      run_and_check("rand", ra, rb, rop, r, c, o, z, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_slice_sequencer.md
# alu_slice_sequencer

Multi-cycle controller that runs 16-bit ALU operations through a single combinational FourBitALU slice, one 4-bit nibble per cycle, LSB nibble first, with carry chained through a register. It sits directly upstream of FourBitALU: it drives the slice's a, b, cin, less and op inputs and consumes its result, cout and overflow outputs. It presents a valid/ready operand interface to the datapath and returns the wide result plus flags.

## Interface
- NSLICES, default 4, number of 4-bit slices per operation; data width W = 4*NSLICES (16).
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE
- in_a, in_b  in  W  operands, latched on accept
- in_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed)
- out_valid  out  1  result available, held until accepted
- out_ready  in  1  consumer accepts result
- out_result  out  W  result
- out_cout, out_overflow, out_zero, out_err  out  1 each  flags
- alu_a, alu_b  out  4  current nibble of latched operands
- alu_cin, alu_less  out  1  slice carry-in; alu_less always 0
- alu_op  out  3  slice opcode
- alu_result  in  4;  alu_cout, alu_overflow  in  1  slice outputs, sampled each RUN cycle

## Operation
- States: IDLE, RUN, DONE. Slice counter idx, 0..NSLICES-1.
- IDLE: in_ready=1. in_valid&in_ready at an edge: latch a, b, op; idx<=0; ->RUN.
- RUN: alu_a/alu_b = nibble idx of latched a/b; alu_op = 110 for SLT, else latched op. Each edge stores alu_result into result nibble idx, stores alu_cout in carry register, idx++. At idx=NSLICES-1 also capture alu_overflow, ->DONE.
- alu_cin: idx=0 -> 1 for SUB/SLT, 0 otherwise; idx>0 -> carry register for ADD/SUB/SLT, 0 for AND/OR.
- DONE: out_valid=1; outputs stable. out_valid&out_ready at an edge ->IDLE.
- Flags: out_cout = final carry for ADD/SUB/SLT, 0 for AND/OR. out_overflow = slice-3 overflow for ADD/SUB, 0 otherwise (including SLT). out_zero = (out_result==0).
- SLT: result = {W-1 zeros, msb(difference) XOR slice-3 overflow}.
- Illegal op (011,100,101): still accepted and run 4 cycles with alu_op=latched op; out_result forced 0, out_err=1, out_zero=1, other flags 0. out_err=0 for legal ops.
- Input ports ignored outside IDLE; latched operands unchanged until next accept.
- Reset (any state, including mid-RUN): state IDLE, idx 0, all registers 0. Reset values: in_ready=1, out_valid=0, out_result=0, all flags 0, alu_a=alu_b=0, alu_cin=0, alu_op=000, alu_less=0. No partial result is ever presented.

## Timing
- Accept at edge E0; slice i evaluated in the cycle after E(i); out_valid high from the cycle after E4 (4-cycle latency from accept edge).
- Result handshake at edge En -> IDLE; in_ready=1 in the cycle after En. Minimum 6 cycles accept-to-accept; no same-cycle result-accept/new-accept overlap.
- out_ready held low: out_valid, out_result and flags held unchanged indefinitely.
- alu_* outputs derive from registered state only; the slice path is combinational within one cycle.

## Test plan
- ADD 0x0001+0x0001 -> out_result 0x0002, cout 0, overflow 0, zero 0, out_valid 4 cycles after accept; ADD 0xFFFF+0x0001 -> 0x0000, cout 1, zero 1, overflow 0.
- SUB 0x0004-0x0001 -> 0x0003, cout 1; ADD 0x7FFF+0x0001 -> 0x8000, overflow 1; carry must visibly ripple across all four slices.
- SLT 0x8000 vs 0x0001 -> 0x0001; SLT 0x7FFF vs 0x8000 -> 0x0000 (overflowing difference, correction exercised); SLT 0x0003 vs 0x0003 -> 0x0000, zero 1.
- AND 0xF0F0 & 0x0FF0 -> 0x00F0, cout 0; OR -> 0xFFF0; op 101 -> result 0x0000, err 1.
- Backpressure: out_ready low 3 cycles after out_valid, change in_a/in_b/in_op meanwhile -> outputs held, in_ready 0, new inputs ignored; out_ready high -> in_ready 1 next cycle.
- Assert rst_n low in RUN after slice 1 -> out_valid 0, out_result 0, in_ready 1 immediately; after release, ADD 0x1234+0x1111 -> 0x2345 correct.
